// File: rtl/ysyx_25060170_idu_pipe_if.sv
// Decoded-bundle channel from the decode stage to EXU.
// master = decode stage, slave = EXU.
interface ysyx_25060170_idu_pipe_if #(
  parameter int XLEN = 32
);
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [4:0]      alu_op_o;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [XLEN-1:0] imm_o;
  logic [XLEN-1:0] rs2_data_o;
  logic [4:0]      rd_addr_o;
  logic            reg_we_o;
  logic [1:0]      wb_sel_o;
  logic            mem_re_o;
  logic            mem_we_o;
  logic [2:0]      mem_size_o;
  logic            jal_o;
  logic            jalr_o;
  logic            branch_o;
  logic [2:0]      br_func_o;
  logic            illegal_o;

  modport master (
    output out_valid_o, out_pc_o, alu_op_o,
    output op1_o, op2_o, imm_o, rs2_data_o,
    output rd_addr_o, reg_we_o, wb_sel_o,
    output mem_re_o, mem_we_o, mem_size_o,
    output jal_o, jalr_o, branch_o, br_func_o,
    output illegal_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_pc_o, alu_op_o,
    input  op1_o, op2_o, imm_o, rs2_data_o,
    input  rd_addr_o, reg_we_o, wb_sel_o,
    input  mem_re_o, mem_we_o, mem_size_o,
    input  jal_o, jalr_o, branch_o, br_func_o,
    input  illegal_o,
    output out_ready_i
  );
endinterface

// File: rtl/ysyx_25060170_idu_pipe.sv
// Registered RV32I decode stage with ebreak halt FSM and flush.
// Define YSYX_IDU_RV32M_EN to decode the M-extension OP encodings.
module ysyx_25060170_idu_pipe #(
  parameter int              XLEN     = 32,
  parameter int              GPR_NUM  = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  output logic [4:0]      rs1_raddr_o,
  output logic [4:0]      rs2_raddr_o,
  input  logic [XLEN-1:0] reg1_rdata_i,
  input  logic [XLEN-1:0] reg2_rdata_i,
  input  logic            flush_i,
  ysyx_25060170_idu_pipe_if.master out_if,
  output logic            halt_o,
  output logic [XLEN-1:0] halt_pc_o,
  output logic [XLEN-1:0] halt_code_o
);

  localparam logic [5:0] GPR_LIM = 6'(GPR_NUM);
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    logic            reg_we;
    logic [1:0]      wb_sel;
    logic            mem_re;
    logic            mem_we;
    logic [2:0]      mem_size;
    logic            jal;
    logic            jalr;
    logic            branch;
    logic [2:0]      br_func;
    logic            illegal;
  } bundle_t;

  state_t  state;
  logic    out_valid_q;
  bundle_t q;
  bundle_t d;

  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        is_ebreak;
  logic        xfer;

  logic known;
  logic f7_ok;
  logic use_rd;
  logic use_rs1;
  logic use_rs2;
  logic bad_reg;

  assign opc = inst_i[6:0];
  assign rd  = inst_i[11:7];
  assign f3  = inst_i[14:12];
  assign rs1 = inst_i[19:15];
  assign rs2 = inst_i[24:20];
  assign f7  = inst_i[31:25];

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25],
                  inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                  inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31],
                  inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};

  assign is_ebreak = (inst_i == 32'h0010_0073);

  // ebreak reports a0 as its exit code, so steer port 1 at x10
  assign rs1_raddr_o = is_ebreak ? 5'd10 : rs1;
  assign rs2_raddr_o = rs2;

  assign in_ready_o = (state == RUN) && !flush_i &&
                      (!out_valid_q || out_if.out_ready_i);
  assign xfer = in_valid_i && in_ready_o;

  function automatic logic [4:0] alu_of(
    input logic [2:0] fn,
    input logic       alt
  );
    logic [4:0] r;
    unique case (fn)
      3'b000: r = alt ? ALU_SUB : ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = alt ? ALU_SRA : ALU_SRL;
      3'b110: r = ALU_OR;
      3'b111: r = ALU_AND;
    endcase
    return r;
  endfunction

  always_comb begin
    d        = '0;
    d.pc     = pc_i;
    d.rs2_data = reg2_rdata_i;
    known    = 1'b1;
    f7_ok    = 1'b1;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    unique case (1'b1)
      opc == 7'b0110111: begin
        d.op2 = imm_u; d.imm = imm_u;
        d.reg_we = 1'b1; use_rd = 1'b1;
      end
      opc == 7'b0010111: begin
        d.op1 = pc_i; d.op2 = imm_u; d.imm = imm_u;
        d.reg_we = 1'b1; use_rd = 1'b1;
      end
      opc == 7'b1101111: begin
        d.op1 = pc_i; d.op2 = 32'd4; d.imm = imm_j;
        d.wb_sel = 2'd2; d.reg_we = 1'b1; d.jal = 1'b1;
        use_rd = 1'b1;
      end
      opc == 7'b1100111: begin
        d.op1 = pc_i; d.op2 = 32'd4; d.imm = imm_i;
        d.wb_sel = 2'd2; d.reg_we = 1'b1; d.jalr = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      opc == 7'b1100011: begin
        d.op1 = reg1_rdata_i; d.op2 = reg2_rdata_i;
        d.imm = imm_b; d.alu_op = ALU_SUB;
        d.branch = 1'b1; d.br_func = f3;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      opc == 7'b0000011: begin
        d.op1 = reg1_rdata_i; d.op2 = imm_i; d.imm = imm_i;
        d.reg_we = 1'b1; d.mem_re = 1'b1; d.wb_sel = 2'd1;
        d.mem_size = f3;
        use_rd = 1'b1; use_rs1 = 1'b1;
      end
      opc == 7'b0100011: begin
        d.op1 = reg1_rdata_i; d.op2 = imm_s; d.imm = imm_s;
        d.mem_we = 1'b1; d.mem_size = f3;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      opc == 7'b0010011: begin
        d.op1 = reg1_rdata_i; d.imm = imm_i;
        d.op2 = (f3[1:0] == 2'b01) ?
                {27'b0, imm_i[4:0]} : imm_i;
        d.alu_op = alu_of(f3, (f3 == 3'b101) && inst_i[30]);
        d.reg_we = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'b001)
          f7_ok = (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      opc == 7'b0110011: begin
        d.op1 = reg1_rdata_i; d.op2 = reg2_rdata_i;
        d.reg_we = 1'b1;
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        unique case (f7)
          7'b0000000: d.alu_op = alu_of(f3, 1'b0);
          7'b0100000: begin
            d.alu_op = alu_of(f3, 1'b1);
            f7_ok = (f3 == 3'b000) || (f3 == 3'b101);
          end
          7'b0000001: begin
`ifdef YSYX_IDU_RV32M_EN
            d.alu_op = {2'b10, f3};
`else
            f7_ok = 1'b0;
`endif
          end
          default: f7_ok = 1'b0;
        endcase
      end
      default: known = 1'b0;
    endcase

    if (use_rd) d.rd = rd;
    bad_reg = (use_rd  && ({1'b0, rd}  >= GPR_LIM)) ||
              (use_rs1 && ({1'b0, rs1} >= GPR_LIM)) ||
              (use_rs2 && ({1'b0, rs2} >= GPR_LIM));
    d.illegal = !known || !f7_ok || bad_reg;

    if (d.illegal) begin
      d.alu_op = ALU_ADD;
      d.reg_we = 1'b0;
      d.mem_re = 1'b0;
      d.mem_we = 1'b0;
      d.jal    = 1'b0;
      d.jalr   = 1'b0;
      d.branch = 1'b0;
    end
    if (d.rd == 5'd0) d.reg_we = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      out_valid_q <= 1'b0;
      q           <= '0;
      halt_o      <= 1'b0;
      halt_pc_o   <= RESET_PC;
      halt_code_o <= '0;
    end else begin
      if (flush_i)
        out_valid_q <= 1'b0;
      else if (xfer)
        out_valid_q <= !is_ebreak;
      else if (out_if.out_ready_i)
        out_valid_q <= 1'b0;

      if (xfer && !is_ebreak) q <= d;

      if (xfer && is_ebreak) begin
        state       <= HALT;
        halt_o      <= 1'b1;
        halt_pc_o   <= pc_i;
        halt_code_o <= reg1_rdata_i;
      end
    end
  end

  assign out_if.out_valid_o = out_valid_q;
  assign out_if.out_pc_o    = q.pc;
  assign out_if.alu_op_o    = q.alu_op;
  assign out_if.op1_o       = q.op1;
  assign out_if.op2_o       = q.op2;
  assign out_if.imm_o       = q.imm;
  assign out_if.rs2_data_o  = q.rs2_data;
  assign out_if.rd_addr_o   = q.rd;
  assign out_if.reg_we_o    = q.reg_we;
  assign out_if.wb_sel_o    = q.wb_sel;
  assign out_if.mem_re_o    = q.mem_re;
  assign out_if.mem_we_o    = q.mem_we;
  assign out_if.mem_size_o  = q.mem_size;
  assign out_if.jal_o       = q.jal;
  assign out_if.jalr_o      = q.jalr;
  assign out_if.branch_o    = q.branch;
  assign out_if.br_func_o   = q.br_func;
  assign out_if.illegal_o   = q.illegal;

endmodule

// File: tb/tb_ysyx_25060170_idu_pipe.sv
// Bench for the registered decode stage: vector table through a
// scoreboard, plus stall, flush, ebreak, reset and RV32E sequences.
module tb_ysyx_25060170_idu_pipe;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  alu;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we;
    logic [1:0]  wb;
    logic        re;
    logic        wm;
    logic [2:0]  sz;
    logic        jal;
    logic        jalr;
    logic        br;
    logic [2:0]  bf;
    logic        ill;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [4:0]  rs1_a;
  logic [4:0]  rs2_a;
  logic [31:0] r1;
  logic [31:0] r2;
  logic        flush;
  logic        halt;
  logic [31:0] halt_pc;
  logic [31:0] halt_code;

  logic        in_valid16;
  logic        in_ready16;
  logic [31:0] inst16;
  logic [4:0]  rs1_a16;
  logic [4:0]  rs2_a16;
  logic        flush16;
  logic        halt16;
  logic [31:0] halt_pc16;
  logic [31:0] halt_code16;

  int n_chk;
  int n_fail;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t cur;
  vec_t ev;

  ysyx_25060170_idu_pipe_if #(.XLEN(32)) oif();
  ysyx_25060170_idu_pipe_if #(.XLEN(32)) oif16();

  ysyx_25060170_idu_pipe u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .pc_i         (pc),
    .inst_i       (inst),
    .rs1_raddr_o  (rs1_a),
    .rs2_raddr_o  (rs2_a),
    .reg1_rdata_i (r1),
    .reg2_rdata_i (r2),
    .flush_i      (flush),
    .out_if       (oif),
    .halt_o       (halt),
    .halt_pc_o    (halt_pc),
    .halt_code_o  (halt_code)
  );

  ysyx_25060170_idu_pipe #(.GPR_NUM(16)) u_dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid16),
    .in_ready_o   (in_ready16),
    .pc_i         (pc),
    .inst_i       (inst16),
    .rs1_raddr_o  (rs1_a16),
    .rs2_raddr_o  (rs2_a16),
    .reg1_rdata_i (r1),
    .reg2_rdata_i (r2),
    .flush_i      (flush16),
    .out_if       (oif16),
    .halt_o       (halt16),
    .halt_pc_o    (halt_pc16),
    .halt_code_o  (halt_code16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp(input vec_t e);
    string p;
    p = $sformatf("pc%h_", e.pc);
    chk({p, "pc"},   oif.out_pc_o,   e.pc);
    chk({p, "alu"},  32'(oif.alu_op_o), 32'(e.alu));
    chk({p, "op1"},  oif.op1_o,      e.op1);
    chk({p, "op2"},  oif.op2_o,      e.op2);
    chk({p, "imm"},  oif.imm_o,      e.imm);
    chk({p, "rs2d"}, oif.rs2_data_o, e.r2);
    chk({p, "rd"},   32'(oif.rd_addr_o), 32'(e.rd));
    chk({p, "we"},   32'(oif.reg_we_o),  32'(e.we));
    chk({p, "wb"},   32'(oif.wb_sel_o),  32'(e.wb));
    chk({p, "re"},   32'(oif.mem_re_o),  32'(e.re));
    chk({p, "wm"},   32'(oif.mem_we_o),  32'(e.wm));
    chk({p, "sz"},   32'(oif.mem_size_o), 32'(e.sz));
    chk({p, "jal"},  32'(oif.jal_o),     32'(e.jal));
    chk({p, "jalr"}, 32'(oif.jalr_o),    32'(e.jalr));
    chk({p, "br"},   32'(oif.branch_o),  32'(e.br));
    chk({p, "bf"},   32'(oif.br_func_o), 32'(e.bf));
    chk({p, "ill"},  32'(oif.illegal_o), 32'(e.ill));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (flush) begin
        sb.delete();
      end else if (oif.out_valid_o && oif.out_ready_i) begin
        chk("sb_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) cmp(sb.pop_front());
      end
      if (in_valid && in_ready && inst != EBREAK)
        sb.push_back(cur);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cur      = v;
    in_valid = 1'b1;
    pc       = v.pc;
    inst     = v.inst;
    r1       = v.r1;
    r2       = v.r2;
  endtask

  task automatic drain(input string nm);
    in_valid = 1'b0;
    oif.out_ready_i = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) tick();
    chk(nm, 32'(sb.size()), 32'd0);
  endtask

  task automatic rst_pulse();
    #2 rst_n = 1'b0;
  endtask

  task automatic rst_release();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    pc = '0;
    inst = '0;
    r1 = '0;
    r2 = '0;
    flush = 1'b0;
    in_valid16 = 1'b0;
    inst16 = '0;
    flush16 = 1'b0;
    oif.out_ready_i = 1'b0;
    oif16.out_ready_i = 1'b1;

    // pc inst r1 r2 | alu op1 op2 imm rd we wb re wm sz jal jalr br bf ill
    tbl.push_back('{32'h8000_0000, 32'hFFF0_8293, 32'd7, 32'd0,
      5'd0, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0004, 32'h0020_81B3, 32'd5, 32'd9,
      5'd0, 32'd5, 32'd9, 32'd0, 5'd3,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0008, 32'h4020_81B3, 32'd5, 32'd9,
      5'd1, 32'd5, 32'd9, 32'd0, 5'd3,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_000C,
      {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd6, 7'b0010011},
      32'hF000_0000, 32'd0,
      5'd7, 32'hF000_0000, 32'd3, 32'h0000_0403, 5'd6,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0014,
      {20'h12345, 5'd7, 7'b0110111}, 32'd0, 32'd0,
      5'd0, 32'd0, 32'h1234_5000, 32'h1234_5000, 5'd7,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0100,
      {20'h00001, 5'd8, 7'b0010111}, 32'd0, 32'd0,
      5'd0, 32'h8000_0100, 32'h1000, 32'h1000, 5'd8,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0010, 32'h0100_00EF, 32'd0, 32'd0,
      5'd0, 32'h8000_0010, 32'd4, 32'd16, 5'd1,
      1'b1, 2'd2, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0200,
      {12'd8, 5'd2, 3'b000, 5'd1, 7'b1100111},
      32'h8000_1000, 32'd0,
      5'd0, 32'h8000_0200, 32'd4, 32'd8, 5'd1,
      1'b1, 2'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0300,
      {1'b1, 6'b111111, 5'd2, 5'd1, 3'b001, 4'b1100, 1'b1,
       7'b1100011},
      32'd3, 32'd3,
      5'd1, 32'd3, 32'd3, 32'hFFFF_FFF8, 5'd0,
      1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0});
    tbl.push_back('{32'h8000_0304,
      {12'd4, 5'd1, 3'b010, 5'd9, 7'b0000011},
      32'h1000, 32'd0,
      5'd0, 32'h1000, 32'd4, 32'd4, 5'd9,
      1'b1, 2'd1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0308,
      {7'd0, 5'd2, 5'd1, 3'b010, 5'd12, 7'b0100011},
      32'h2000, 32'hDEAD_BEEF,
      5'd0, 32'h2000, 32'd12, 32'd12, 5'd0,
      1'b0, 2'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
`ifdef YSYX_IDU_RV32M_EN
    tbl.push_back('{32'h8000_030C, 32'h0220_81B3, 32'd6, 32'd7,
      5'd16, 32'd6, 32'd7, 32'd0, 5'd3,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
`else
    tbl.push_back('{32'h8000_030C, 32'h0220_81B3, 32'd6, 32'd7,
      5'd0, 32'd6, 32'd7, 32'd0, 5'd3,
      1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
`endif
    tbl.push_back('{32'h8000_0310,
      {7'b0100000, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011},
      32'd1, 32'd2,
      5'd0, 32'd1, 32'd2, 32'd0, 5'd3,
      1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    tbl.push_back('{32'h8000_0314, 32'h0000_0000, 32'd0, 32'd0,
      5'd0, 32'd0, 32'd0, 32'd0, 5'd0,
      1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});
    tbl.push_back('{32'h8000_0318,
      {12'd1, 5'd1, 3'b000, 5'd0, 7'b0010011},
      32'd4, 32'd0,
      5'd0, 32'd4, 32'd1, 32'd1, 5'd0,
      1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_031C,
      {12'hFFF, 5'd1, 3'b100, 5'd4, 7'b0010011},
      32'h0F0F_0F0F, 32'd0,
      5'd5, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0320,
      {7'b0100000, 5'd2, 5'd1, 3'b101, 5'd5, 7'b0110011},
      32'h8000_0000, 32'd4,
      5'd7, 32'h8000_0000, 32'd4, 32'd0, 5'd5,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0324,
      {7'd0, 5'd2, 5'd1, 3'b011, 5'd5, 7'b0110011},
      32'd1, 32'd2,
      5'd4, 32'd1, 32'd2, 32'd0, 5'd5,
      1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{32'h8000_0328,
      {7'b0000001, 5'd3, 5'd1, 3'b101, 5'd6, 7'b0010011},
      32'd9, 32'd0,
      5'd0, 32'd9, 32'd3, 32'h0000_0023, 5'd6,
      1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1});

    ev = tbl[0];
    ev.pc = 32'h8000_0020;
    ev.inst = EBREAK;
    ev.r1 = 32'h2A;
    ev.r2 = 32'd0;

    #12;
    chk("rst_valid", 32'(oif.out_valid_o), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_halt_pc", halt_pc, 32'h8000_0000);
    chk("rst_halt_code", halt_code, 32'd0);
    chk("rst_out_pc", oif.out_pc_o, 32'd0);
    chk("rst_op1", oif.op1_o, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_release();

    oif.out_ready_i = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick();
    end
    drain("table_drain");

    oif.out_ready_i = 1'b0;
    drive(tbl[0]);
    #1;
    chk("bp_rdy_first", 32'(in_ready), 32'd1);
    chk("bp_rs1_addr", 32'(rs1_a), 32'd1);
    tick();
    drive(tbl[1]);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_rdy_stall", 32'(in_ready), 32'd0);
      chk("bp_valid_hold", 32'(oif.out_valid_o), 32'd1);
      chk("bp_pc_hold", oif.out_pc_o, tbl[0].pc);
      chk("bp_op1_hold", oif.op1_o, tbl[0].op1);
      tick();
    end
    oif.out_ready_i = 1'b1;
    #1;
    chk("bp_rdy_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_valid", 32'(oif.out_valid_o), 32'd1);
    chk("bp_second_pc", oif.out_pc_o, tbl[1].pc);
    drain("bp_drain");

    oif.out_ready_i = 1'b0;
    drive(tbl[2]);
    tick();
    flush = 1'b1;
    drive(ev);
    #1;
    chk("fl_rdy", 32'(in_ready), 32'd0);
    chk("eb_rs1_addr", 32'(rs1_a), 32'd10);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 32'(oif.out_valid_o), 32'd0);
    chk("fl_no_halt", 32'(halt), 32'd0);
    tick();
    chk("fl_valid_after", 32'(oif.out_valid_o), 32'd0);
    chk("fl_sb_empty", 32'(sb.size()), 32'd0);

    drive(tbl[4]);
    tick();
    drive(ev);
    #1;
    chk("eb_stalled", 32'(in_ready), 32'd0);
    oif.out_ready_i = 1'b1;
    #1;
    chk("eb_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("eb_halt", 32'(halt), 32'd1);
    chk("eb_halt_pc", halt_pc, 32'h8000_0020);
    chk("eb_halt_code", halt_code, 32'h2A);
    chk("eb_in_ready", 32'(in_ready), 32'd0);
    chk("eb_no_bundle", 32'(oif.out_valid_o), 32'd0);
    drive(tbl[0]);
    repeat (3) tick();
    chk("halt_sticky", 32'(halt), 32'd1);
    chk("halt_rdy", 32'(in_ready), 32'd0);
    chk("halt_no_out", 32'(oif.out_valid_o), 32'd0);
    chk("halt_sb_empty", 32'(sb.size()), 32'd0);
    in_valid = 1'b0;
    rst_pulse();
    #1;
    chk("rst_clr_halt", 32'(halt), 32'd0);
    chk("rst_clr_pc", halt_pc, 32'h8000_0000);
    chk("rst_clr_code", halt_code, 32'd0);
    rst_release();
    chk("run_again_rdy", 32'(in_ready), 32'd1);

    oif.out_ready_i = 1'b0;
    drive(tbl[1]);
    tick();
    in_valid = 1'b0;
    chk("mid_held", 32'(oif.out_valid_o), 32'd1);
    rst_pulse();
    #1;
    chk("mid_rst_valid", 32'(oif.out_valid_o), 32'd0);
    chk("mid_rst_pc", oif.out_pc_o, 32'd0);
    chk("mid_rst_rd", 32'(oif.rd_addr_o), 32'd0);
    rst_release();

    inst16 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd20, 7'b0110011};
    in_valid16 = 1'b1;
    tick();
    chk("e_x20_valid", 32'(oif16.out_valid_o), 32'd1);
    chk("e_x20_ill", 32'(oif16.illegal_o), 32'd1);
    chk("e_x20_we", 32'(oif16.reg_we_o), 32'd0);
    inst16 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd16, 7'b0110011};
    tick();
    chk("e_x16_ill", 32'(oif16.illegal_o), 32'd1);
    inst16 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd15, 7'b0110011};
    tick();
    chk("e_x15_ill", 32'(oif16.illegal_o), 32'd0);
    chk("e_x15_we", 32'(oif16.reg_we_o), 32'd1);
    inst16 = {7'd0, 5'd17, 5'd1, 3'b000, 5'd3, 7'b0110011};
    tick();
    in_valid16 = 1'b0;
    chk("e_rs2_ill", 32'(oif16.illegal_o), 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_idu_pipe.md
# ysyx_25060170_idu_pipe

Registered, handshaked RV32I decode stage: the next-generation successor of the single-cycle combinational decoder. It sits between IFU and EXU. It accepts one instruction per valid/ready transfer, reads GPR rs1/rs2, and presents a fully decoded bundle one cycle later. It also owns the halt state machine for `ebreak` and supports flushing after a redirect.

## Interface
- `XLEN`, default 32: data/PC width; only 32 is supported.
- `GPR_NUM`, default 32: architectural register count, 32 (RV32I) or 16 (RV32E); any register index ≥ `GPR_NUM` is illegal.
- `RESET_PC`, default 32'h8000_0000: value of `halt_pc_o` after reset.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid_i` input 1: IFU holds a valid instruction.
- `in_ready_o` output 1: stage accepts this cycle.
- `pc_i` input XLEN: instruction PC.
- `inst_i` input 32: instruction word.
- `rs1_raddr_o` output 5: GPR read address 1 (combinational from `inst_i`).
- `rs2_raddr_o` output 5: GPR read address 2 (combinational from `inst_i`).
- `reg1_rdata_i` input XLEN: GPR data 1, same cycle.
- `reg2_rdata_i` input XLEN: GPR data 2, same cycle.
- `flush_i` input 1: kill the held bundle and block acceptance this cycle.
- `out_valid_o` output 1: decoded bundle valid.
- `out_ready_i` input 1: EXU accepts.
- `out_pc_o` output XLEN: PC of the bundle.
- `alu_op_o` output 5: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS2, 16–23 MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- `op1_o` output XLEN: ALU operand 1.
- `op2_o` output XLEN: ALU operand 2.
- `imm_o` output XLEN: immediate.
- `rs2_data_o` output XLEN: store data / branch comparand.
- `rd_addr_o` output 5: destination register.
- `reg_we_o` output 1: GPR write enable.
- `wb_sel_o` output 2: writeback select, 0 ALU, 1 MEM, 2 PC+4.
- `mem_re_o` output 1: load.
- `mem_we_o` output 1: store.
- `mem_size_o` output 3: funct3 of load/store.
- `jal_o` output 1: JAL.
- `jalr_o` output 1: JALR.
- `branch_o` output 1: conditional branch.
- `br_func_o` output 3: branch funct3.
- `illegal_o` output 1: undecodable instruction.
- `halt_o` output 1: `ebreak` retired, sticky.
- `halt_pc_o` output XLEN: PC of the `ebreak`.
- `halt_code_o` output XLEN: value of a0 (x10) at `ebreak`.

## Operation
- **States:** RUN, HALT; reset state is RUN.
- **Transfer:** a transfer happens when `in_valid_i && in_ready_o`.
  - `in_ready_o` = (state==RUN) && !`flush_i` && (!`out_valid_o` || `out_ready_i`).
- **Decoded instructions:** LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, plus `ebreak` (32'h0010_0073).
- **Operand selection:**
  - LUI: `op1`=0, `op2`=imm, ALU op ADD.
  - AUIPC: `op1`=pc, `op2`=imm.
  - JAL/JALR: `op1`=pc, `op2`=4, `wb_sel`=2; `imm_o` carries the target offset.
  - BRANCH: `op1`=rs1, `op2`=rs2, SUB.
  - LOAD/STORE: `op1`=rs1, `op2`=imm, ADD.
  - OP-IMM: `op1`=rs1, `op2`=imm.
  - OP: `op1`=rs1, `op2`=rs2.
  - Shift-immediate uses `imm[4:0]`; SRAI is detected by `inst[30]`.
- **Illegal instructions:** unknown opcode, bad funct7, or any register index ≥ `GPR_NUM`.
  - Bundle is forwarded with `illegal_o`=1.
  - All side-effect enables (`reg_we`, `mem_re`, `mem_we`, `jal`, `jalr`, `branch`) are 0.
- **x0 destination:** `rd`=0 forces `reg_we_o`=0.
- **ebreak:** while `inst_i` is `ebreak`, `rs1_raddr_o`=10. On transfer:
  - `halt_pc_o`←pc and `halt_code_o`←`reg1_rdata_i`; `halt_o`←1.
  - State goes to HALT; no bundle is produced.
  - HALT holds until reset; `in_ready_o`=0.
  - A bundle already held still drains normally.
- **Flush:** `flush_i` clears `out_valid_o` on the next edge, regardless of `out_ready_i`.
  - A flush in the same cycle as an `ebreak` presentation blocks that transfer.

## Timing
- **Latency:** one cycle from transfer to `out_valid_o`. Throughput is one instruction per cycle while `out_ready_i`=1.
- **Output stability:** the output bundle is registered and holds stable while `out_valid_o && !out_ready_i`.
- **Combinational paths:** none from `out_ready_i` to bundle data. `in_ready_o` depends combinationally on `out_ready_i`, `flush_i` and state.
- **Reset values (asynchronous, take effect immediately):**
  - `out_valid_o`=0 and `halt_o`=0, with state RUN.
  - `halt_pc_o`=`RESET_PC`; `halt_code_o`=0.
  - All bundle fields = 0.
- **Reset mid-operation:** discards the held bundle and the halt status.

## Configuration
- **`YSYX_IDU_RV32M_EN` defined:** OP with funct7=0000001 decodes to `alu_op` 16+funct3, with `op1`=rs1 and `op2`=rs2.
- **Undefined:** the same encodings set `illegal_o`=1, and `alu_op` values 16–23 are never produced.

## Test plan
- **addi:** reset, then send `addi x5,x1,-1` (32'hFFF0_8293) at pc 0x8000_0000 with `reg1`=7 → next cycle:
  - `out_valid`=1, `op1`=7, `op2`=0xFFFF_FFFF, `alu_op`=0, `rd`=5, `reg_we`=1, `wb_sel`=0.
- **Back-pressure:** hold `out_ready_i`=0 with `in_valid`=1 for 3 cycles → `in_ready`=0 after the first transfer and the bundle stays unchanged. Release → the second instruction appears the next cycle.
- **jal:** send `jal x1,+16` (32'h0100_00EF) at pc 0x8000_0010 →
  - `jal_o`=1, `op1`=0x8000_0010, `op2`=4, `imm`=16, `wb_sel`=2.
- **ebreak with a0=0x2A** at pc 0x8000_0020 → `rs1_raddr`=10.
  - Next cycle: `halt_o`=1, `halt_pc`=0x8000_0020, `halt_code`=0x2A, `in_ready`=0.
  - Held until `rst_n` pulses low.
- **Flush:** flush with a bundle held and `out_ready`=0 → `out_valid`=0 next cycle, and no transfer in the flush cycle.
- **RV32M gating:** send `mul x3,x1,x2` (32'h0220_81B3) → `alu_op`=16 with the macro defined; `illegal_o`=1 and `reg_we`=0 without it. With `GPR_NUM`=16, `add x20,x1,x2` → `illegal_o`=1.
